// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: select encodings, default width
// and the controller state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SHL = 3'b001;
  localparam logic [2:0] SEL_SHR = 3'b010;
  localparam logic [2:0] SEL_CNT = 3'b011;
  localparam logic [2:0] SEL_AND = 3'b100;
  localparam logic [2:0] SEL_OR  = 3'b101;
  localparam logic [2:0] SEL_XOR = 3'b110;
  localparam logic [2:0] SEL_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// scanning upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;
  logic hit;

  // Priority scan: step k visits requester (ptr + k) mod NREQ; first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        hit     = (((int'(ptr) + k) % NREQ) == i) & req[i] & ~found;
        gnt[i]  = gnt[i] | hit;
        gnt_idx = hit ? IDW'(i) : gnt_idx;
        found   = found | hit;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between NREQ requesters: round-robin accept, registered ALU
// drive for one cycle, then a held valid/ready response tagged with the ID.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREQ  = 2,
  parameter int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_sel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy
);

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    rr_next;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              accept;
  logic [WIDTH-1:0]  pick_a;
  logic [WIDTH-1:0]  pick_b;
  logic [2:0]        pick_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The handshake is combinational but must read as zero while reset is held
  assign req_ready = (reset_n && (state == ST_IDLE)) ? gnt : '0;
  assign accept    = (state == ST_IDLE) && (|req_valid);
  assign rr_next   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Select the granted requester's operands and opcode from the packed buses
  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = SEL_NOP;
    for (int i = 0; i < NREQ; i++) begin
      pick_a   = (gnt_idx == IDW'(i)) ? req_a[i*WIDTH +: WIDTH] : pick_a;
      pick_b   = (gnt_idx == IDW'(i)) ? req_b[i*WIDTH +: WIDTH] : pick_b;
      pick_sel = (gnt_idx == IDW'(i)) ? req_sel[i*3 +: 3]       : pick_sel;
    end
  end

  // Controller FSM with all outputs registered; alu_sel parks on NOP when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= SEL_NOP;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a   <= pick_a;
            alu_b   <= pick_b;
            alu_sel <= pick_sel;
            rsp_id  <= gnt_idx;
            rr_ptr  <= rr_next;
            busy    <= 1'b1;
            state   <= ST_ISSUE;
          end else begin
            alu_sel <= SEL_NOP;
          end
        end
        ST_ISSUE: begin
          rsp_data  <= alu_result;
          rsp_err   <= (alu_sel == SEL_NOP);
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            alu_sel   <= SEL_NOP;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          alu_sel   <= SEL_NOP;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU stand-in; table-driven
// single operations plus backpressure, mid-operation reset and contention.
module tb_alu_sched;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_id;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  cnt;

  int nvec;
  int nmis;

  alu_sched #(.WIDTH(8), .NREQ(2), .IDW(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 8'd1;

  // Behavioural ALU: shifts are by one, NOP yields zero
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = {alu_a[6:0], 1'b0};
      3'b010:  alu_result = {1'b0, alu_a[7:1]};
      3'b011:  alu_result = cnt;
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a | alu_b;
      3'b110:  alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  // One full operation from requester r with rsp_ready held high; starts and ends at a negedge in IDLE
  task automatic op(input int r, input logic [7:0] a, input logic [7:0] b,
                    input logic [2:0] sel, input logic [7:0] exp, input logic err);
    logic [1:0] oh;
    oh = 2'b01 << r;
    req_valid = oh;
    req_a[r*8 +: 8]   = a;
    req_b[r*8 +: 8]   = b;
    req_sel[r*3 +: 3] = sel;
    rsp_ready = 1'b1;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(oh));
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_no_rsp", 32'(rsp_valid), 32'd0);
    chk("issue_ready_low", 32'(req_ready), 32'd0);
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_sel", 32'(alu_sel), 32'(sel));
    req_valid = 2'b00;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_id", 32'(rsp_id), 32'(r));
    chk("rsp_err", 32'(rsp_err), 32'(err));
    @(negedge clk);
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_sel_nop", 32'(alu_sel), 32'h7);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    cnt = 8'h00;
    tbl[0] = '{0, 8'h3C, 8'h05, 3'b000, 8'h41, 1'b0};
    tbl[1] = '{1, 8'hF0, 8'h3C, 3'b110, 8'hCC, 1'b0};
    tbl[2] = '{1, 8'h12, 8'h34, 3'b111, 8'h00, 1'b1};
    tbl[3] = '{0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b0};
    tbl[4] = '{0, 8'h81, 8'h01, 3'b001, 8'h02, 1'b0};
    tbl[5] = '{1, 8'h81, 8'h01, 3'b010, 8'h40, 1'b0};
    tbl[6] = '{0, 8'hF0, 8'h3C, 3'b100, 8'h30, 1'b0};
    tbl[7] = '{1, 8'hF0, 8'h0F, 3'b101, 8'hFF, 1'b0};

    reset_n   = 1'b0;
    req_valid = 2'b01;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    req_sel   = 6'b000000;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'h7);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_sel_nop", 32'(alu_sel), 32'h7);

    for (int i = 0; i < 8; i++)
      op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].exp, tbl[i].err);

    // Backpressure: XOR held for 5 cycles while requester 1 waits
    req_valid = 2'b01;
    req_a[7:0] = 8'hF0;
    req_b[7:0] = 8'h3C;
    req_sel[2:0] = 3'b110;
    rsp_ready = 1'b0;
    #1;
    chk("bp_accept", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    req_a[15:8] = 8'h01;
    req_b[15:8] = 8'h01;
    req_sel[5:3] = 3'b000;
    #1;
    chk("bp_issue_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'hCC);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_next_data", 32'(rsp_data), 32'h02);
    chk("bp_next_id", 32'(rsp_id), 32'd1);
    @(negedge clk);

    // Reset during ISSUE after requester 0 was granted (pointer moved to 1)
    req_valid = 2'b01;
    req_a[7:0] = 8'h10;
    req_b[7:0] = 8'h20;
    req_sel[2:0] = 3'b000;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    req_valid = 2'b11;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_sel", 32'(alu_sel), 32'h7);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);

    // Contention: both requesters held; grants must alternate starting at 0
    req_a = {8'h0F, 8'h01};
    req_b = {8'hFF, 8'h02};
    req_sel = {3'b110, 3'b000};
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("cont_grant", 32'(req_ready), 32'(2'b01 << (k % 2)));
      @(negedge clk);
      chk("cont_issue_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("cont_valid", 32'(rsp_valid), 32'd1);
      chk("cont_id", 32'(rsp_id), 32'(k % 2));
      chk("cont_data", 32'(rsp_data), (k % 2 == 0) ? 32'h03 : 32'hF0);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
